// File: rtl/vdp_bus_pkg.sv
// Shared types for the VDP CPU bus bridge: FSM state, posted-write FIFO entry
// and the TI-order bit reversal helper.
package vdp_bus_pkg;

  localparam int MAX_ADDR_W = 8;
  localparam int MAX_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    WR_REQ,
    RD_REQ
  } state_t;

  // Fields are sized for the widest supported bus; callers cast to ADDR_W/DATA_W.
  typedef struct packed {
    logic [MAX_ADDR_W-1:0] adr;
    logic [MAX_DATA_W-1:0] data;
  } fifo_entry_t;

  // Reverses the low 'width' bits of d; bits at and above 'width' return 0.
  function automatic logic [MAX_DATA_W-1:0] bit_reverse(input logic [MAX_DATA_W-1:0] d,
                                                        input int width);
    logic [MAX_DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_DATA_W; i++) begin
      if (i < width) r[i] = d[width-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/vdp_bus_fifo.sv
// Posted-write FIFO for the VDP bus bridge: synchronous push/pop with
// full/empty flags and an occupancy count that saturates at DEPTH.
module vdp_bus_fifo
  import vdp_bus_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n_w,
  input  logic          push,
  input  fifo_entry_t   din,
  input  logic          pop,
  output fifo_entry_t   dout,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  fifo_entry_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n_w) begin
    if (!rst_n_w) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // NOTE: storage carries no reset; the pointers and level define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/vdp_cpu_bus_bridge.sv
// Host-CPU strobe bridge into the VDP REQ/WRT/ADR/DBO/ACK port.
// Define VDP_BUS_STATS_EN to add acknowledged write/read counters.
module vdp_cpu_bus_bridge
  import vdp_bus_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 2,
  parameter int DATA_W      = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int BIT_REVERSE = 1
) (
  input  logic                        clk,
  input  logic                        rst_n_w,
  input  logic                        csr_n,
  input  logic                        csw_n,
  input  logic [ADDR_W-1:0]           mode,
  input  logic [DATA_W-1:0]           cd_in,
  output logic [DATA_W-1:0]           cd_out,
  output logic                        cd_oe,
  output logic                        vdp_req,
  output logic                        vdp_wrt,
  output logic [ADDR_W-1:0]           vdp_adr,
  output logic [DATA_W-1:0]           vdp_dbo,
  input  logic                        vdp_ack,
  input  logic [DATA_W-1:0]           vdp_dbi,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  output logic                        collision
`ifdef VDP_BUS_STATS_EN
  ,
  output logic [15:0]                 wr_count,
  output logic [15:0]                 rd_count
`endif
);

  logic [SYNC_STAGES-1:0] csr_sync, csw_sync;
  logic                   csr_filt, csw_filt;
  logic                   csr_filt_d, csw_filt_d;
  logic                   csr_ev, csw_ev, wr_only, rd_only;
  logic [DATA_W-1:0]      cd_cap;
  fifo_entry_t            push_entry, head;
  logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic                   rd_pending;
  logic [ADDR_W-1:0]      rd_adr;
  state_t                 state;

  // NOTE: every flop here uses non-blocking assignment so the shift chain moves one stage per edge.
  always_ff @(posedge clk or negedge rst_n_w) begin
    if (!rst_n_w) begin
      csr_sync   <= '1;
      csw_sync   <= '1;
      csr_filt   <= 1'b1;
      csw_filt   <= 1'b1;
      csr_filt_d <= 1'b1;
      csw_filt_d <= 1'b1;
    end else begin
      csr_sync <= {csr_sync[SYNC_STAGES-2:0], csr_n};
      csw_sync <= {csw_sync[SYNC_STAGES-2:0], csw_n};
      // Filtered level follows only when the last two stages agree.
      if (csr_sync[SYNC_STAGES-1] == csr_sync[SYNC_STAGES-2]) csr_filt <= csr_sync[SYNC_STAGES-1];
      if (csw_sync[SYNC_STAGES-1] == csw_sync[SYNC_STAGES-2]) csw_filt <= csw_sync[SYNC_STAGES-1];
      csr_filt_d <= csr_filt;
      csw_filt_d <= csw_filt;
    end
  end

  assign csr_ev  = csr_filt_d & ~csr_filt;
  assign csw_ev  = csw_filt_d & ~csw_filt;
  assign wr_only = csw_ev & ~csr_ev;
  assign rd_only = csr_ev & ~csw_ev;

  assign cd_cap = (BIT_REVERSE != 0) ? DATA_W'(bit_reverse(MAX_DATA_W'(cd_in), DATA_W)) : cd_in;
  assign push_entry = '{adr: MAX_ADDR_W'(mode), data: MAX_DATA_W'(cd_cap)};
  assign fifo_push  = wr_only & ~fifo_full;
  assign fifo_pop   = (state == IDLE) & ~fifo_empty;

  vdp_bus_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n_w (rst_n_w),
    .push    (fifo_push),
    .din     (push_entry),
    .pop     (fifo_pop),
    .dout    (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Read path is combinational from the pins so CPU access time is met.
  assign cd_out = (BIT_REVERSE != 0) ? DATA_W'(bit_reverse(MAX_DATA_W'(vdp_dbi), DATA_W)) : vdp_dbi;
  assign cd_oe  = ~csr_n & csw_n;

  always_ff @(posedge clk or negedge rst_n_w) begin
    if (!rst_n_w) begin
      state      <= IDLE;
      vdp_req    <= 1'b0;
      vdp_wrt    <= 1'b0;
      vdp_adr    <= '0;
      vdp_dbo    <= '0;
      rd_pending <= 1'b0;
      rd_adr     <= '0;
      overflow   <= 1'b0;
      collision  <= 1'b0;
    end else begin
      if (csw_ev & csr_ev)    collision <= 1'b1;
      if (wr_only & fifo_full) overflow <= 1'b1;
      // A read strobe while one is already pending merges into it.
      if (rd_only & ~rd_pending) begin
        rd_pending <= 1'b1;
        rd_adr     <= mode;
      end

      case (state)
        IDLE: begin
          // Writes drain first so the VDP sees accesses in CPU bus order.
          if (!fifo_empty) begin
            vdp_adr <= ADDR_W'(head.adr);
            vdp_dbo <= DATA_W'(head.data);
            vdp_wrt <= 1'b1;
            vdp_req <= 1'b1;
            state   <= WR_REQ;
          end else if (rd_pending) begin
            vdp_adr <= rd_adr;
            vdp_wrt <= 1'b0;
            vdp_req <= 1'b1;
            state   <= RD_REQ;
          end
        end
        WR_REQ: begin
          if (vdp_ack) begin
            vdp_req <= 1'b0;
            vdp_wrt <= 1'b0;
            state   <= IDLE;
          end
        end
        RD_REQ: begin
          if (vdp_ack) begin
            vdp_req    <= 1'b0;
            vdp_wrt    <= 1'b0;
            rd_pending <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VDP_BUS_STATS_EN
  always_ff @(posedge clk or negedge rst_n_w) begin
    if (!rst_n_w) begin
      wr_count <= '0;
      rd_count <= '0;
    end else if (vdp_ack) begin
      if (state == WR_REQ && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      if (state == RD_REQ && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vdp_cpu_bus_bridge.sv
// Scoreboard bench for vdp_cpu_bus_bridge: stimulus queues expected VDP
// transactions, a monitor pops and compares each request the DUT raises.
module tb_vdp_cpu_bus_bridge;

  localparam int SYNC_STAGES = 2;
  localparam int ADDR_W      = 2;
  localparam int DATA_W      = 8;
  localparam int FIFO_DEPTH  = 4;
  localparam int BIT_REVERSE = 1;
  localparam int LW          = $clog2(FIFO_DEPTH) + 1;

  logic              clk;
  logic              rst_n_w;
  logic              csr_n, csw_n;
  logic [ADDR_W-1:0] mode;
  logic [DATA_W-1:0] cd_in, cd_out, vdp_dbo, vdp_dbi;
  logic              cd_oe, vdp_req, vdp_wrt, vdp_ack;
  logic [ADDR_W-1:0] vdp_adr;
  logic [LW-1:0]     fifo_level;
  logic              overflow, collision;
`ifdef VDP_BUS_STATS_EN
  logic [15:0]       wr_count, rd_count;
`endif

  vdp_cpu_bus_bridge #(
    .SYNC_STAGES (SYNC_STAGES),
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .BIT_REVERSE (BIT_REVERSE)
  ) dut (
    .clk        (clk),
    .rst_n_w    (rst_n_w),
    .csr_n      (csr_n),
    .csw_n      (csw_n),
    .mode       (mode),
    .cd_in      (cd_in),
    .cd_out     (cd_out),
    .cd_oe      (cd_oe),
    .vdp_req    (vdp_req),
    .vdp_wrt    (vdp_wrt),
    .vdp_adr    (vdp_adr),
    .vdp_dbo    (vdp_dbo),
    .vdp_ack    (vdp_ack),
    .vdp_dbi    (vdp_dbi),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .collision  (collision)
`ifdef VDP_BUS_STATS_EN
    ,
    .wr_count   (wr_count),
    .rd_count   (rd_count)
`endif
  );

  typedef struct {
    bit                wrt;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] dbo;
  } txn_t;

  txn_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   req_count = 0;
  int   acked_wr = 0;
  int   acked_rd = 0;
  bit   hold_ack = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // TI numbering: CPU bit 0 is the MSB, so the byte is mirrored end to end.
  function automatic logic [DATA_W-1:0] ti_order(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    if (BIT_REVERSE == 0) return d;
    for (int i = 0; i < DATA_W; i++) r[i] = d[DATA_W-1-i];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every new request is matched against the head of the scoreboard.
  txn_t cur;
  bit   req_prev = 1'b0;
  always @(negedge clk) begin
    if (vdp_req && !req_prev) begin
      req_count++;
      cur = '{wrt: vdp_wrt, adr: vdp_adr, dbo: vdp_dbo};
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_req: wrt=%0b adr=%0h dbo=%0h with empty scoreboard", vdp_wrt, vdp_adr, vdp_dbo);
      end else begin
        txn_t e;
        e = exp_q.pop_front();
        check("req_wrt", 32'(vdp_wrt), 32'(e.wrt));
        check("req_adr", 32'(vdp_adr), 32'(e.adr));
        if (e.wrt) check("req_dbo", 32'(vdp_dbo), 32'(e.dbo));
      end
    end else if (vdp_req) begin
      check("req_hold", {vdp_wrt, vdp_adr, vdp_dbo}, {cur.wrt, cur.adr, cur.dbo});
    end
    req_prev = vdp_req;
  end

  // VDP model: acks after a random delay, supplies random read data every cycle.
  initial begin
    int dly;
    vdp_ack = 1'b0;
    dly = $urandom_range(0, 3);
    forever begin
      @(posedge clk);
      #1;
      if (vdp_req && !hold_ack) begin
        if (dly == 0) begin
          if (vdp_wrt) acked_wr++;
          else         acked_rd++;
          vdp_ack = 1'b1;
          @(posedge clk);
          #1;
          vdp_ack = 1'b0;
          check("req_drop_after_ack", 32'(vdp_req), 32'd0);
          dly = $urandom_range(0, 3);
        end else begin
          dly--;
        end
      end
    end
  end

  initial begin
    vdp_dbi = '0;
    forever begin
      @(posedge clk);
      #1;
      vdp_dbi = DATA_W'($urandom);
    end
  end

  task automatic bus_op(input bit is_read, input logic [ADDR_W-1:0] adr,
                        input logic [DATA_W-1:0] data, input bit expect_txn,
                        input int lo, input int hi);
    if (expect_txn) exp_q.push_back('{wrt: !is_read, adr: adr, dbo: ti_order(data)});
    @(posedge clk);
    #1;
    mode  = adr;
    cd_in = data;
    if (is_read) csr_n = 1'b0;
    else         csw_n = 1'b0;
    repeat (lo) begin
      @(negedge clk);
      if (is_read) begin
        check("cd_oe_read", 32'(cd_oe), 32'd1);
        check("cd_out", 32'(cd_out), 32'(ti_order(vdp_dbi)));
      end else begin
        check("cd_oe_write", 32'(cd_oe), 32'd0);
      end
    end
    @(posedge clk);
    #1;
    csr_n = 1'b1;
    csw_n = 1'b1;
    repeat (hi) @(posedge clk);
  endtask

  task automatic wait_req(input int budget);
    int n = 0;
    while (!vdp_req && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("req_seen", 32'(vdp_req), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || vdp_req || fifo_level != '0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("drain_pending", 32'(exp_q.size()), 32'd0);
    check("drain_req_low", 32'(vdp_req), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] burst [6];
    int n;
    int rc;

    rst_n_w = 1'b0;
    csr_n   = 1'b1;
    csw_n   = 1'b1;
    mode    = '0;
    cd_in   = '0;
    #1;
    check("rst_req", 32'(vdp_req), 32'd0);
    check("rst_wrt", 32'(vdp_wrt), 32'd0);
    check("rst_adr", 32'(vdp_adr), 32'd0);
    check("rst_dbo", 32'(vdp_dbo), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_collision", 32'(collision), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n_w = 1'b1;
    repeat (3) @(posedge clk);

    // Single write: 0x80 in TI order arrives at the VDP as 0x01.
    exp_q.push_back('{wrt: 1'b1, adr: 2'd1, dbo: 8'h01});
    @(posedge clk);
    #1;
    mode  = 2'b01;
    cd_in = 8'h80;
    csw_n = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!vdp_req && n < 20);
    check("wr_latency", 32'(n), 32'(SYNC_STAGES + 3));
    repeat (10 - n) @(posedge clk);
    #1;
    csw_n = 1'b1;
    wait_idle(100);

    // Burst with the VDP stalled: one write goes in flight, FIFO_DEPTH queue up, the rest drop.
    hold_ack = 1'b1;
    for (int k = 0; k < 6; k++) burst[k] = DATA_W'($urandom);
    bus_op(1'b0, 2'd2, burst[0], 1'b1, 4, 6);
    wait_req(20);
    for (int k = 1; k < 6; k++) bus_op(1'b0, ADDR_W'(k), burst[k], k <= FIFO_DEPTH, 4, 6);
    check("burst_level", 32'(fifo_level), 32'(FIFO_DEPTH));
    check("burst_overflow", 32'(overflow), 32'd1);
    hold_ack = 1'b0;
    wait_idle(200);
    check("overflow_sticky", 32'(overflow), 32'd1);

    // Three queued writes then a read: the read must follow all writes.
    hold_ack = 1'b1;
    for (int k = 0; k < 3; k++) bus_op(1'b0, ADDR_W'(k + 1), DATA_W'($urandom), 1'b1, 4, 6);
    bus_op(1'b1, 2'd0, '0, 1'b1, 6, 2);
    @(negedge clk);
    check("cd_oe_idle", 32'(cd_oe), 32'd0);
    hold_ack = 1'b0;
    wait_idle(200);

    // One-cycle glitch on csw_n must be filtered out.
    rc = req_count;
    @(posedge clk);
    #1;
    csw_n = 1'b0;
    @(posedge clk);
    #1;
    csw_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("glitch_level", 32'(fifo_level), 32'd0);
    check("glitch_no_req", 32'(req_count), 32'(rc));

    // Simultaneous read and write strobes: both dropped, collision flagged.
    rc = req_count;
    @(posedge clk);
    #1;
    mode  = 2'd3;
    cd_in = 8'h5A;
    csr_n = 1'b0;
    csw_n = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    csr_n = 1'b1;
    csw_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("collision_flag", 32'(collision), 32'd1);
    check("collision_no_req", 32'(req_count), 32'(rc));
    check("collision_level", 32'(fifo_level), 32'd0);

    // Reset while a write request is outstanding.
    hold_ack = 1'b1;
    bus_op(1'b0, 2'd2, 8'hC3, 1'b1, 4, 2);
    wait_req(20);
    @(posedge clk);
    #1;
    rst_n_w = 1'b0;
    #1;
    check("midrst_req", 32'(vdp_req), 32'd0);
    check("midrst_wrt", 32'(vdp_wrt), 32'd0);
    check("midrst_level", 32'(fifo_level), 32'd0);
    check("midrst_overflow", 32'(overflow), 32'd0);
    check("midrst_collision", 32'(collision), 32'd0);
    @(negedge clk);
    rst_n_w  = 1'b1;
    acked_wr = 0;
    acked_rd = 0;
    hold_ack = 1'b0;
    repeat (2) @(posedge clk);
    bus_op(1'b0, 2'd1, 8'h3C, 1'b1, 5, 6);
    wait_idle(100);

    // Randomised mix of reads and writes.
    for (int k = 0; k < 40; k++) begin
      bus_op($urandom_range(0, 3) == 0, ADDR_W'($urandom), DATA_W'($urandom), 1'b1,
             $urandom_range(3, 8), $urandom_range(6, 10));
    end
    wait_idle(300);
    check("final_overflow", 32'(overflow), 32'd0);
    check("final_collision", 32'(collision), 32'd0);

`ifdef VDP_BUS_STATS_EN
    check("wr_count", 32'(wr_count), 32'(acked_wr));
    check("rd_count", 32'(rd_count), 32'(acked_rd));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
